// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares the MemReadWrite data port between CPU and debug readout
//            using req/gnt/rvalid handshakes with a fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int DBG_ADDR_W   = 10,
    parameter int READ_LAT     = 3,
    parameter int INFER_OFFSET = 6300,
    parameter int MAX_WAIT     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]     cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_W-1:0]     cpu_rdata,
    input  logic                  dbg_req,
    input  logic [DBG_ADDR_W-1:0] dbg_addr,
    output logic                  dbg_gnt,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic                  mem_en,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  busy
);

    localparam int c_lat_w  = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
    localparam int c_wait_w = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [c_lat_w-1:0]  c_read_lat = c_lat_w'(READ_LAT);
    localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);
    localparam logic [ADDR_W-1:0]   c_offset   = ADDR_W'(INFER_OFFSET);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } state_t;

    state_t              r_state, w_state;
    logic                r_owner, w_owner;   // 1: debug port owns the read in flight
    logic [c_lat_w-1:0]  r_lat, w_lat;
    logic [c_wait_w-1:0] r_wait, w_wait;
    logic                w_dbg_win;
    logic                w_cpu_gnt, w_dbg_gnt, w_cpu_rvalid, w_dbg_rvalid;
    logic                w_mem_en, w_mem_ren, w_mem_wen;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_din, w_cpu_rdata, w_dbg_rdata;

    always_comb begin
        w_state      = r_state;
        w_owner      = r_owner;
        w_lat        = r_lat;
        w_cpu_gnt    = 1'b0;
        w_dbg_gnt    = 1'b0;
        w_cpu_rvalid = 1'b0;
        w_dbg_rvalid = 1'b0;
        w_mem_en     = mem_en;
        w_mem_ren    = mem_ren;
        w_mem_wen    = mem_wen;
        w_mem_addr   = mem_addr;
        w_mem_din    = mem_din;
        w_cpu_rdata  = cpu_rdata;
        w_dbg_rdata  = dbg_rdata;
        // Debug wins when the CPU is quiet or the debug side has starved long enough
        w_dbg_win    = (r_state == S_IDLE) && dbg_req && (!cpu_req || (r_wait >= c_max_wait));

        case (r_state)
            S_IDLE: begin
                w_mem_en  = 1'b0;
                w_mem_ren = 1'b0;
                w_mem_wen = 1'b0;
                if (w_dbg_win) begin
                    w_state    = S_RD;
                    w_owner    = 1'b1;
                    w_lat      = c_lat_w'(1);
                    w_dbg_gnt  = 1'b1;
                    w_mem_en   = 1'b1;
                    w_mem_ren  = 1'b1;
                    w_mem_addr = ADDR_W'(dbg_addr) + c_offset;
                end else if (cpu_req) begin
                    w_owner    = 1'b0;
                    w_lat      = c_lat_w'(1);
                    w_cpu_gnt  = 1'b1;
                    w_mem_en   = 1'b1;
                    w_mem_addr = cpu_addr;
                    if (cpu_we) begin
                        w_state   = S_WR;
                        w_mem_wen = 1'b1;
                        w_mem_din = cpu_wdata;
                    end else begin
                        w_state   = S_RD;
                        w_mem_ren = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (r_lat == c_read_lat) begin
                    w_state   = S_IDLE;
                    w_mem_en  = 1'b0;
                    w_mem_ren = 1'b0;
                    if (r_owner) begin
                        w_dbg_rdata  = mem_dout;
                        w_dbg_rvalid = 1'b1;
                    end else begin
                        w_cpu_rdata  = mem_dout;
                        w_cpu_rvalid = 1'b1;
                    end
                end else begin
                    w_lat = r_lat + 1'b1;
                end
            end
            S_WR: begin
                w_state   = S_IDLE;
                w_mem_en  = 1'b0;
                w_mem_wen = 1'b0;
            end
            default: begin
                w_state   = S_IDLE;
                w_mem_en  = 1'b0;
                w_mem_ren = 1'b0;
                w_mem_wen = 1'b0;
            end
        endcase

        if (w_dbg_win)
            w_wait = '0;
        else if (dbg_req && (r_wait < c_max_wait))
            w_wait = r_wait + 1'b1;
        else
            w_wait = r_wait;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner    <= 1'b0;
            r_lat      <= '0;
            r_wait     <= '0;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            mem_en     <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            busy       <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_owner    <= w_owner;
            r_lat      <= w_lat;
            r_wait     <= w_wait;
            cpu_gnt    <= w_cpu_gnt;
            dbg_gnt    <= w_dbg_gnt;
            cpu_rvalid <= w_cpu_rvalid;
            dbg_rvalid <= w_dbg_rvalid;
            cpu_rdata  <= w_cpu_rdata;
            dbg_rdata  <= w_dbg_rdata;
            mem_en     <= w_mem_en;
            mem_ren    <= w_mem_ren;
            mem_wen    <= w_mem_wen;
            mem_addr   <= w_mem_addr;
            mem_din    <= w_mem_din;
            busy       <= (w_state != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized and directed bench with a transaction-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int READ_LAT     = 3;
    localparam int INFER_OFFSET = 6300;
    localparam int MAX_WAIT     = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        dbg_req = 1'b0;
    logic [9:0]  dbg_addr = '0;
    logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
    logic [31:0] cpu_rdata, dbg_rdata, mem_din;
    logic [31:0] mem_dout = '0;
    logic        mem_en, mem_ren, mem_wen, busy;
    logic [15:0] mem_addr;

    // Second instance exercises address wrap-around with a large offset
    logic        z1 = 1'b0;
    logic [15:0] z16 = '0;
    logic [31:0] z32 = '0;
    logic [31:0] wr_mem_dout = 32'hCAFEF00D;
    logic        wr_dbg_req = 1'b0;
    logic [9:0]  wr_dbg_addr = '0;
    logic        wr_cpu_gnt, wr_cpu_rvalid, wr_dbg_gnt, wr_dbg_rvalid;
    logic [31:0] wr_cpu_rdata, wr_dbg_rdata, wr_mem_din;
    logic        wr_mem_en, wr_mem_ren, wr_mem_wen, wr_busy;
    logic [15:0] wr_mem_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(READ_LAT), .INFER_OFFSET(INFER_OFFSET), .MAX_WAIT(MAX_WAIT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_ren(mem_ren), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    mem_port_arbiter #(.READ_LAT(READ_LAT), .INFER_OFFSET(16'hFFFF), .MAX_WAIT(MAX_WAIT)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(z1), .cpu_we(z1), .cpu_addr(z16), .cpu_wdata(z32),
        .cpu_gnt(wr_cpu_gnt), .cpu_rvalid(wr_cpu_rvalid), .cpu_rdata(wr_cpu_rdata),
        .dbg_req(wr_dbg_req), .dbg_addr(wr_dbg_addr), .dbg_gnt(wr_dbg_gnt),
        .dbg_rvalid(wr_dbg_rvalid), .dbg_rdata(wr_dbg_rdata),
        .mem_en(wr_mem_en), .mem_ren(wr_mem_ren), .mem_wen(wr_mem_wen),
        .mem_addr(wr_mem_addr), .mem_din(wr_mem_din), .mem_dout(wr_mem_dout), .busy(wr_busy)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [15:0] a);
        if (a == 16'h0010) return 32'h2402000A;
        return ({16'h0, a} * 32'h9E3779B1) + 32'h01234567;
    endfunction

    // Memory seen by the DUT: writes land and reads present mid-cycle
    logic [31:0] mem [logic [15:0]];
    always @(negedge clk) begin
        if (mem_en && mem_wen) mem[mem_addr] = mem_din;
        mem_dout = mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
    end

    // Reference model: decides grants from the arbitration rules per clock edge
    typedef struct {
        bit          port;   // 1 = debug
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned e;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] ref_mem [logic [15:0]];
    int unsigned cyc = 0;
    int unsigned next_arb = 0;
    int          m_wait = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_wait   = 0;
            next_arb = 0;
        end else begin
            bit   dwin, cwin;
            txn_t t;
            dwin = (cyc >= next_arb) && dbg_req && (!cpu_req || m_wait >= MAX_WAIT);
            cwin = (cyc >= next_arb) && cpu_req && !dwin;
            if (dwin || cwin) begin
                t.port = dwin;
                t.e    = cyc;
                if (dwin) begin
                    t.we    = 1'b0;
                    t.addr  = 16'((int'(dbg_addr) + INFER_OFFSET) % 65536);
                    t.wdata = '0;
                end else begin
                    t.we    = cpu_we;
                    t.addr  = cpu_addr;
                    t.wdata = cpu_wdata;
                end
                t.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : pat(t.addr);
                if (t.we) begin
                    ref_mem[t.addr] = t.wdata;
                    next_arb = cyc + 2;
                end else begin
                    next_arb = cyc + READ_LAT + 1;
                end
                exp_q.push_back(t);
            end
            if (dwin) m_wait = 0;
            else if (dbg_req && m_wait < MAX_WAIT) m_wait++;
        end
    end

    // Monitor: pops expected transactions and checks the port every cycle
    txn_t        cur;
    bit          act = 1'b0;
    logic [31:0] e_cpu_rd = '0, e_dbg_rd = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            act      = 1'b0;
            e_cpu_rd = '0;
            e_dbg_rd = '0;
        end else begin
            bit          eg_c, eg_d, erv_c, erv_d, newwr;
            logic [18:0] ectl;
            int          k;
            eg_c = 0; eg_d = 0; erv_c = 0; erv_d = 0; newwr = 0; ectl = '0;
            if (!act && exp_q.size() > 0 && exp_q[0].e + 1 == cyc) begin
                cur  = exp_q.pop_front();
                act  = 1'b1;
                eg_c = !cur.port;
                eg_d = cur.port;
            end
            if (act) begin
                k = int'(cyc - cur.e);
                if (cur.we) begin
                    ectl  = {3'b101, cur.addr};
                    newwr = 1'b1;
                    act   = 1'b0;
                end else if (k <= READ_LAT) begin
                    ectl = {3'b110, cur.addr};
                end else begin
                    erv_c = !cur.port;
                    erv_d = cur.port;
                    if (cur.port) e_dbg_rd = cur.rdata;
                    else          e_cpu_rd = cur.rdata;
                    act = 1'b0;
                end
            end
            check("cpu_gnt", cpu_gnt, eg_c);
            check("dbg_gnt", dbg_gnt, eg_d);
            if (ectl[18]) check("mem_ctl", {mem_en, mem_ren, mem_wen, mem_addr}, ectl);
            else          check("mem_ctl_idle", {mem_en, mem_ren, mem_wen}, 3'b000);
            if (newwr) check("mem_din", mem_din, cur.wdata);
            check("busy", busy, ectl[18]);
            check("cpu_rvalid", cpu_rvalid, erv_c);
            check("dbg_rvalid", dbg_rvalid, erv_d);
            check("cpu_rdata", cpu_rdata, e_cpu_rd);
            check("dbg_rdata", dbg_rdata, e_dbg_rd);
        end
    end

    task automatic cpu_op(input bit we, input logic [15:0] a, input logic [31:0] d);
        int n;
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_gnt && n < 200);
        check("cpu_gnt_wait", cpu_gnt, 1'b1);
        cpu_req   = 1'b0;
        cpu_we    = 1'($urandom);
        cpu_addr  = 16'($urandom);
        cpu_wdata = $urandom;
        @(negedge clk);
    endtask

    task automatic dbg_op(input logic [9:0] a, output logic [15:0] ga);
        int n;
        dbg_addr = a; dbg_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!dbg_gnt && n < 200);
        check("dbg_gnt_wait", dbg_gnt, 1'b1);
        ga       = mem_addr;
        dbg_req  = 1'b0;
        dbg_addr = 10'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_rvalid(input bit port, output int n);
        n = 0;
        while (!(port ? dbg_rvalid : cpu_rvalid) && n < 50) begin @(negedge clk); n++; end
    endtask

    initial begin
        int          n, n_cpu;
        bit          dbg_done;
        logic [15:0] ga;

        repeat (3) @(negedge clk);
        check("reset_outs", {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_ren, mem_wen, busy}, 8'h00);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_data", {cpu_rdata, dbg_rdata, mem_addr, mem_din}, '0);

        // Address wrap on the large-offset instance
        wr_dbg_addr = 10'd1023; wr_dbg_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!wr_dbg_gnt && n < 50);
        check("t6_gnt", wr_dbg_gnt, 1'b1);
        check("t6_addr", wr_mem_addr, 16'h03FE);
        check("t6_ctl", {wr_mem_en, wr_mem_ren, wr_mem_wen, wr_busy, wr_cpu_gnt}, 5'b11010);
        wr_dbg_req = 1'b0;
        n = 0;
        while (!wr_dbg_rvalid && n < 50) begin @(negedge clk); n++; end
        check("t6_lat", n, READ_LAT);
        check("t6_rdata", wr_dbg_rdata, 32'hCAFEF00D);
        check("t6_cpu_side", {wr_cpu_rvalid, wr_cpu_rdata, wr_mem_din}, '0);

        // CPU read
        cpu_op(1'b0, 16'h0010, '0);
        wait_rvalid(1'b0, n);
        check("t1_lat", n, READ_LAT - 1);
        check("t1_rdata", cpu_rdata, 32'h2402000A);

        // CPU write then readback
        cpu_op(1'b1, 16'h0020, 32'hDEADBEEF);
        cpu_op(1'b0, 16'h0020, '0);
        wait_rvalid(1'b0, n);
        check("t2_rdata", cpu_rdata, 32'hDEADBEEF);

        // Debug read at offset
        dbg_op(10'd5, ga);
        check("t3_addr", ga, 16'd6305);
        wait_rvalid(1'b1, n);
        check("t3_rdata", dbg_rdata, pat(16'd6305));
        repeat (2) @(negedge clk);

        // Continuous contention: CPU keeps winning until the debug side starves
        n_cpu = 0; dbg_done = 0;
        cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_req = 1'b1;
        dbg_addr = 10'd7; dbg_req = 1'b1;
        for (int i = 0; i < 300 && !dbg_done; i++) begin
            @(negedge clk);
            if (dbg_gnt) begin dbg_done = 1; dbg_req = 1'b0; cpu_req = 1'b0; end
            else if (cpu_gnt) begin n_cpu++; cpu_req = 1'b0; end
            else cpu_req = 1'b1;
        end
        check("t4_dbg_gnt", dbg_done, 1'b1);
        check("t4_cpu_grants", n_cpu, (MAX_WAIT + READ_LAT) / (READ_LAT + 1));
        repeat (READ_LAT + 4) @(negedge clk);

        // Reset during cycle 2 of a read
        cpu_op(1'b0, 16'h0010, '0);
        #2 rst_n = 1'b0;
        #1 check("t5_outs", {cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_en, mem_ren, mem_wen, busy}, 8'h00);
        check("t5_data", {cpu_rdata, dbg_rdata}, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (READ_LAT + 4) @(negedge clk);
        check("t5_idle", busy, 1'b0);

        // Random traffic from both requesters
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    cpu_op(1'($urandom_range(0, 1)), 16'h0100 + 16'($urandom_range(0, 31)), $urandom);
                end
            end
            begin
                logic [15:0] g;
                repeat (30) begin
                    repeat ($urandom_range(0, 5)) @(negedge clk);
                    dbg_op(10'($urandom_range(0, 1023)), g);
                end
            end
        join
        repeat (20) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
